// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encoding and bit-level helper functions
// for the chunk engine and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Zero count from bit 255 downward; an all-zero word yields 256.
  function automatic logic [8:0] count_leading_zeros(input logic [255:0] v);
    logic [8:0] n;
    logic       seen;
    n    = '0;
    seen = 1'b0;
    for (int i = 255; i >= 0; i--) begin
      if (v[i]) seen = 1'b1;
      else if (!seen) n = n + 9'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, K[t], W[t]) -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha256_chunk_engine.sv
// Iterative SHA-256 compressor: one 512-bit chunk per 66 cycles, chaining H
// across chunks and publishing digest plus leading-zero count on the last one.
module sha256_chunk_engine
  import sha256_pkg::*;
#(
  parameter int ZW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [511:0]  chunk,
  input  logic          chunk_valid,
  input  logic          chunk_first,
  input  logic          chunk_last,
  output logic          chunk_ready,
  output logic          busy,
  output logic [255:0]  HASH,
  output logic          hash_valid,
  output logic [ZW-1:0] zero_bits
);

  state_t state_reg, state_next;

  logic [5:0]    round_reg;
  logic [31:0]   h_reg    [8];
  logic [31:0]   work_reg [8];
  logic [31:0]   w_reg    [16];
  logic          last_reg;
  logic [255:0]  hash_reg;
  logic [ZW-1:0] zero_bits_reg;
  logic          hash_valid_reg;

  logic [31:0]   round_out [8];
  logic [31:0]   h_new     [8];
  logic [255:0]  h_new_flat;
  logic [31:0]   w_new;

  always_comb begin
    state_next  = state_reg;
    chunk_ready = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        chunk_ready = 1'b1;
        if (chunk_valid) state_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (round_reg == 6'd63) state_next = FINAL;
      end
      FINAL: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  sha256_round u_round (
    .a      (work_reg[0]),
    .b      (work_reg[1]),
    .c      (work_reg[2]),
    .d      (work_reg[3]),
    .e      (work_reg[4]),
    .f      (work_reg[5]),
    .g      (work_reg[6]),
    .h      (work_reg[7]),
    .k      (K[round_reg]),
    .w      (w_reg[0]),
    .a_next (round_out[0]),
    .b_next (round_out[1]),
    .c_next (round_out[2]),
    .d_next (round_out[3]),
    .e_next (round_out[4]),
    .f_next (round_out[5]),
    .g_next (round_out[6]),
    .h_next (round_out[7])
  );

  // Window holds W[t..t+15]; slot 15 refills with W[t+16] each round.
  assign w_new = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];

  // h_reg carries the chunk's base, so the feed-forward add needs no extra copy.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_feedforward
      assign h_new[gi]                   = h_reg[gi] + work_reg[gi];
      assign h_new_flat[255-32*gi -: 32] = h_new[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      round_reg      <= '0;
      last_reg       <= 1'b0;
      hash_reg       <= '0;
      zero_bits_reg  <= '0;
      hash_valid_reg <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i]    <= IV[i];
        work_reg[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
    end else begin
      hash_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (chunk_valid) begin
            for (int i = 0; i < 16; i++) w_reg[i] <= chunk[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              h_reg[i]    <= chunk_first ? IV[i] : h_reg[i];
              work_reg[i] <= chunk_first ? IV[i] : h_reg[i];
            end
            last_reg  <= chunk_last;
            round_reg <= '0;
          end
        end
        ROUND: begin
          for (int i = 0; i < 8; i++) work_reg[i] <= round_out[i];
          for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
          w_reg[15] <= w_new;
          round_reg <= round_reg + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_new[i];
          if (last_reg) begin
            hash_reg       <= h_new_flat;
            zero_bits_reg  <= ZW'(count_leading_zeros(h_new_flat));
            hash_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HASH       = hash_reg;
  assign zero_bits  = zero_bits_reg;
  assign hash_valid = hash_valid_reg;

endmodule

// File: tb/tb_sha256_chunk_engine.sv
// Scoreboard bench for sha256_chunk_engine: known vectors, busy/reset corner
// cases and random chained chunks against a whole-block SHA-256 model.
module tb_sha256_chunk_engine;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [511:0] chunk = '0;
  logic         chunk_valid = 1'b0;
  logic         chunk_first = 1'b0;
  logic         chunk_last  = 1'b0;
  logic         chunk_ready;
  logic         busy;
  logic [255:0] HASH;
  logic         hash_valid;
  logic [8:0]   zero_bits;

  sha256_chunk_engine #(.ZW(9)) dut (
    .clock       (clock),
    .reset       (reset),
    .chunk       (chunk),
    .chunk_valid (chunk_valid),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last),
    .chunk_ready (chunk_ready),
    .busy        (busy),
    .HASH        (HASH),
    .hash_valid  (hash_valid),
    .zero_bits   (zero_bits)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] TIV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_HASH =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_HASH =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return hout;
  endfunction

  function automatic logic [8:0] lead0(input logic [255:0] x);
    int n = 0;
    while (n < 256 && x[255-n] == 1'b0) n++;
    return 9'(n);
  endfunction

  typedef struct {
    logic [255:0] hash;
    logic [8:0]   zbits;
    int           exp_edge;
  } exp_t;

  exp_t         sb_q [$];
  logic [255:0] model_h = TIV;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_chunk(input logic [511:0] blk, input logic first, input logic last,
                            input logic use_k, input logic [255:0] k_hash,
                            input logic [8:0] k_z, output int t_acc);
    int waited = 0;
    logic [255:0] nh;
    exp_t e;
    chunk       = blk;
    chunk_first = first;
    chunk_last  = last;
    chunk_valid = 1'b1;
    while (!chunk_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!chunk_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=ready_low required=ready_high");
    end
    t_acc = cyc + 1;
    @(negedge clock);
    chunk_valid = 1'b0;
    $display("accept edge=%0d first=%0b last=%0b", t_acc, first, last);
    nh      = compress(first ? TIV : model_h, blk);
    model_h = nh;
    if (last) begin
      e.hash     = use_k ? k_hash : nh;
      e.zbits    = use_k ? k_z : lead0(nh);
      e.exp_edge = t_acc + 65;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every hash_valid must match the oldest expectation, on its exact cycle.
  always @(negedge clock) begin
    if (reset && hash_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hash_valid actual=pulse@%0d HASH=%h required=no_pulse", cyc, HASH);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (HASH !== e.hash || zero_bits !== e.zbits || cyc != e.exp_edge) begin
          errors++;
          $display("FAIL digest actual=%h/%0d@%0d required=%h/%0d@%0d",
                   HASH, zero_bits, cyc, e.hash, e.zbits, e.exp_edge);
        end else begin
          $display("digest edge=%0d HASH=%h zero_bits=%0d", cyc, HASH, zero_bits);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, bad_ready, bad_busy, waited;
    logic [511:0] blk;

    repeat (3) @(negedge clock);
    check("reset_hash",        HASH,               '0);
    check("reset_zero_bits",   256'(zero_bits),    '0);
    check("reset_hash_valid",  256'(hash_valid),   '0);
    check("reset_busy",        256'(busy),         '0);
    check("reset_chunk_ready", 256'(chunk_ready),  256'd1);
    reset = 1'b1;
    @(negedge clock);

    // Known single-block and two-block vectors.
    send_chunk(ABC_BLK,   1'b1, 1'b1, 1'b1, ABC_HASH,   9'd0, t1);
    send_chunk(EMPTY_BLK, 1'b1, 1'b1, 1'b1, EMPTY_HASH, 9'd0, t1);
    send_chunk(TWO_BLK1,  1'b1, 1'b0, 1'b0, '0,         9'd0, t1);
    send_chunk(TWO_BLK2,  1'b0, 1'b1, 1'b1, TWO_HASH,   9'd2, t1);

    // A competing chunk held during compression must be ignored until ready returns.
    send_chunk(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_HASH, 9'd0, t1);
    chunk       = EMPTY_BLK;
    chunk_first = 1'b1;
    chunk_last  = 1'b1;
    chunk_valid = 1'b1;
    bad_ready = 0;
    bad_busy  = 0;
    for (int i = 0; i < 65; i++) begin
      if (chunk_ready !== 1'b0) bad_ready++;
      if (busy !== 1'b1) bad_busy++;
      @(negedge clock);
    end
    check("busy_ready_low_cycles", 256'(bad_ready), '0);
    check("busy_high_cycles",      256'(bad_busy),  '0);
    send_chunk(EMPTY_BLK, 1'b1, 1'b1, 1'b1, EMPTY_HASH, 9'd0, t2);
    check("accept_after_busy_edge", 256'(t2), 256'(t1 + 66));

    // Back-to-back acceptance.
    send_chunk(ABC_BLK,   1'b1, 1'b1, 1'b1, ABC_HASH,   9'd0, t1);
    send_chunk(EMPTY_BLK, 1'b1, 1'b1, 1'b1, EMPTY_HASH, 9'd0, t2);
    check("back_to_back_edge", 256'(t2), 256'(t1 + 66));

    // Reset at T+30 abandons the chunk and restores the IV.
    send_chunk(ABC_BLK, 1'b1, 1'b1, 1'b1, ABC_HASH, 9'd0, t1);
    repeat (29) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb_q.delete();
    model_h = TIV;
    check("midreset_hash",        HASH,              '0);
    check("midreset_zero_bits",   256'(zero_bits),   '0);
    check("midreset_chunk_ready", 256'(chunk_ready), 256'd1);
    check("midreset_busy",        256'(busy),        '0);
    repeat (80) @(negedge clock);
    send_chunk(ABC_BLK, 1'b0, 1'b1, 1'b1, ABC_HASH, 9'd0, t1);

    // Random multi-chunk messages; one message continues from the previous digest.
    for (int m = 0; m < 6; m++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom();
        repeat ($urandom_range(0, 2)) @(negedge clock);
        send_chunk(blk, (b == 0) && (m != 3), b == nb - 1, 1'b0, '0, 9'd0, t1);
      end
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    check("scoreboard_drained", 256'(sb_q.size()), '0);
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_chunk_engine.md
Name: sha256_chunk_engine

Overview:
- SHA-256 compression stage directly downstream of the mining FSM.
- Consumes 512-bit message chunks, each with a first/last tag. Runs 64 rounds, one per cycle.
- Accumulates the intermediate hash across chunks. After the last chunk it presents the 256-bit digest and its leading-zero count, which the FSM uses for its difficulty check.

Parameters:
- ZW, 9, width of the leading-zero count output (holds values 0..256).

Ports:
- clock  in  1  system clock; all logic updates on the rising edge
- reset  in  1  synchronous, active-low reset
- chunk  in  512  message block; word 0 = chunk[511:480], word 15 = chunk[31:0]
- chunk_valid  in  1  chunk, first and last are valid this cycle
- chunk_first  in  1  first block of a message; load IV before compressing
- chunk_last  in  1  final block of a message; publish the digest after compressing
- chunk_ready  out  1  engine can accept a chunk this cycle
- busy  out  1  compression in progress
- HASH  out  256  digest; H0 = HASH[255:224], H7 = HASH[31:0]
- hash_valid  out  1  one-cycle pulse; HASH and zero_bits are updated
- zero_bits  out  ZW  number of leading zero bits of HASH, counted from bit 255

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, round counter=0.
  - H0..H7 = SHA-256 IV (6a09e667 … 5be0cd19).
  - HASH=0, zero_bits=0, hash_valid=0, busy=0, chunk_ready=1.
  - Reset has priority over every other event. Reset during ROUND or FINAL abandons the chunk; no hash_valid is produced.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - chunk_ready=1, busy=0.
  - On chunk_valid & chunk_ready at edge T:
    - latch W[0..15] from chunk;
    - base = IV if chunk_first, otherwise the current H;
    - a..h = base;
    - latch chunk_last;
    - go to ROUND, counter=0.
- ROUND:
  - chunk_ready=0, busy=1.
  - One round per edge, edges T+1..T+64, using K[t] and W[t] for t=0..63.
  - W[t] for t≥16 comes from a 16-word rolling schedule: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
  - All adds are 32-bit and wrap; there is no carry out.
  - After t=63, go to FINAL.
- FINAL, at edge T+65:
  - Hi = base_i + a..h_i, mod 2^32.
  - If the latched last flag is set:
    - HASH = new H;
    - zero_bits = leading-zero count of new H (256 if H is all zero);
    - hash_valid=1 for exactly the cycle after T+65.
  - If last is not set, HASH and zero_bits hold their values.
  - Go to IDLE. chunk_ready=1 from the cycle after T+65.
- Throughput and latency:
  - One chunk per 66 cycles. Back-to-back acceptance is possible at edge T+66.
  - A single-block message has hash_valid high during cycle T+66.
- chunk_valid while chunk_ready=0 is ignored. The source must hold the chunk until it is accepted.
- chunk_first and chunk_last may both be 1 (single-block message).
- First chunk after reset with chunk_first=0 uses H=IV, because reset loads IV.
- HASH and zero_bits hold their values until the next digest or reset. hash_valid is 0 at all other times.

Decomposition:
- Package sha256_pkg holds:
  - the K[0..63] constant array;
  - the IV[0..7] constants;
  - state encoding constants for IDLE, ROUND and FINAL;
  - functions for rotr, Ch, Maj, Sigma0, Sigma1, sigma0 and sigma1.
- Sub-module sha256_round: purely combinational, one compression round. Inputs a..h, K[t] and W[t]; outputs the next a..h. The engine instantiates it once.
- Leading-zero count: a function in the package, not a separate module.

Test Plan:
- "abc" single block: chunk = 61626380 followed by zero words, last word 00000018, first=last=1 -> hash_valid in cycle T+66, HASH = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, zero_bits = 0.
- Empty message: chunk = 80000000 followed by zero words, length 0, first=last=1 -> HASH = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, zero_bits = 0.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits):
  - block 1 sent with first=1, last=0 -> no hash_valid;
  - block 2 sent with first=0, last=1 -> HASH = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, zero_bits = 2.
- Busy protection: assert chunk_valid with a different chunk during cycles T+1..T+65 -> chunk_ready=0 throughout, the chunk is ignored, and the "abc" result is unchanged. The next chunk is accepted at T+66.
- Reset mid-operation: send "abc", drive reset=0 at T+30 -> no hash_valid, HASH=0, chunk_ready=1. Then resend "abc" with first=0 -> the correct "abc" digest (IV was restored).
- Back-to-back: send "abc" and then the empty-message chunk, the second at T+66 -> two hash_valid pulses 66 cycles apart, with the digests above in order.
